conv_engine: RTL and testbench
==============================

Name: conv_engine

Overview:
- Convolution stage downstream of the barcode decoder.
- Once the 64x64 8-bit image is in SRAM and kernel/stride/dilation have been decoded, it reads the image through the shared single-port SRAM read interface.
- It applies a 3x3 signed kernel with zero padding, selectable stride and dilation, and streams rounded, clamped 8-bit results with raster output addresses.
- The core arbitration mux grants this block the SRAM after the decode phase ends.

Parameters:
IMG_W, 64, image width/height in pixels
DATA_W, 8, pixel and weight width
ADDR_W, 12, SRAM/output address width
FRAC, 7, weight fractional bits (Q1.7)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start pulse; parameters sampled on this cycle
i_kernel  in  8  kernel size; only 3 legal
i_stride  in  8  stride; 1 or 2 legal
i_dilation  in  8  dilation; 1 or 2 legal
i_weight  in  72  nine signed Q1.7 weights, tap k at bits [8k+7:8k], k = 3*row + col
o_sram_addr  out  12  read address, row*64+col
o_sram_cen  out  1  chip enable, active low
o_sram_wen  out  1  held 1 (read-only)
i_sram_q  in  8  read data, valid the cycle after the address is issued
o_out_data  out  8  result pixel
o_out_addr  out  12  result index r*(64/S)+c
o_out_valid  out  1  one-cycle result strobe
o_busy  out  1  high from start acceptance until o_done
o_err  out  1  sticky illegal-parameter flag, cleared on next accepted start
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: i_clk, i_rst_n asynchronous active-low, as decided.
  - All outputs 0, except o_sram_cen=1 and o_sram_wen=1.
  - FSM returns to IDLE and the accumulator clears.
  - Reset mid-frame aborts with no further outputs and no o_done.
- FSM: IDLE -> (i_start, params legal) RUN -> (last pixel output) DONE -> IDLE.
  - IDLE -> (i_start, params illegal) DONE with o_err=1 and no outputs.
  - DONE lasts 1 cycle and drives o_done=1.
  - i_start while busy is ignored.
- Weights and parameters are latched on i_start; later changes to those inputs do not matter.
- Output grid:
  - Output size N = 64/S; pixels run (r,c), r,c in 0..N-1, in raster order.
  - Centre is (r*S, c*S).
  - Tap (i,j), i,j in 0..2, is at (r*S+(i-1)*D, c*S+(j-1)*D).
- Per-pixel schedule, period exactly 10 cycles:
  - Cycles 0..8 issue taps k=0..8.
  - In-bounds tap: o_sram_cen=0 with its address.
  - Out-of-bounds tap: o_sram_cen=1 and a zero-contribution flag is piped one cycle.
  - Cycles 1..9 accumulate pixel*weight.
  - o_out_valid=1 in cycle 10, which is also cycle 0 of the next pixel.
  - The first o_out_valid comes 10 cycles after the RUN entry cycle.
  - o_done comes the cycle after the last o_out_valid.
- Arithmetic:
  - Each product is unsigned 8b pixel times signed 8b weight, held in 17b signed.
  - The accumulator is 21b signed.
  - result = (acc + 64) >>> 7 (arithmetic shift), clamped to 0..255.
- Row/column counters wrap at N; o_out_addr increments by 1 from 0 to N*N-1.
- o_out_data/o_out_addr hold their value when o_out_valid=0.

Decomposition:
- Shared package holds:
  - IMG_W, FRAC, tap count 9
  - legal K/S/D constants
  - FSM state encoding
  - rounding constant 64
- One sub-module, conv_mac: multiply, accumulate, round and clamp. Inputs are pixel, weight, zero flag and clear; outputs are acc and the sat8 result.
- conv_engine keeps the FSM, tap/pixel counters and address generation.

Test Plan:
- All pixels 100, all weights 0x10, S=1, D=1 -> 4096 outputs in 40961 cycles to o_done.
  - Interior = 113, corner (0,0) = 50, edge (0,5) = 75.
  - o_out_addr runs 0..4095.
- Same image and weights, S=2, D=2 -> 1024 outputs, addr 0..1023, out(0,0) = 50, out(1,1) = 113.
  - The taps of out(0,0) read only addresses 0, 2, 128, 130.
- Pixels 255, all weights 0x80 -> every output 0 (negative clamp).
- Pixels 255, all weights 0x7F -> interior 255 (positive clamp).
- Illegal params (stride 3, or kernel 5) -> o_done the cycle after i_start, o_err=1, no o_out_valid, o_sram_cen stays 1.
- Assert i_rst_n low at output 500 of an S=1 run -> outputs zeroed immediately, no o_done.
  - A new i_start then completes a full frame correctly with o_err=0.

Source files
------------

// File: rtl/conv_engine_pkg.sv
// Shared constants, FSM encoding and parameter-legality helper for the
// convolution engine and its MAC datapath.
package conv_engine_pkg;

    localparam int IMG_W  = 64;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int FRAC   = 7;
    localparam int CRD_W  = $clog2(IMG_W);
    localparam int NTAPS  = 9;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 21;
    localparam int ROUND  = 64;

    localparam logic [7:0] K_LEGAL = 8'd3;
    localparam logic [7:0] S_MIN   = 8'd1;
    localparam logic [7:0] S_MAX   = 8'd2;
    localparam logic [7:0] D_MIN   = 8'd1;
    localparam logic [7:0] D_MAX   = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic params_ok(
        input logic [7:0] k,
        input logic [7:0] s,
        input logic [7:0] d
    );
        return (k == K_LEGAL) &&
               (s >= S_MIN) && (s <= S_MAX) &&
               (d >= D_MIN) && (d <= D_MAX);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate with round-half-up and clamp to 0..255.
// Ports: en (tap data valid), zero (padding tap), clr (restart sum),
// pixel/weight operands, acc (running sum), res (sat8 of acc + term).
module conv_mac
    import conv_engine_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     en,
    input  logic                     zero,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        pixel,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0]        res
);

    localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(ROUND);

    logic signed [PROD_W-1:0] px_s;
    logic signed [PROD_W-1:0] wt_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rnd;

    // Unsigned pixel times signed weight, both widened to the product size.
    assign px_s = $signed({{(PROD_W-DATA_W){1'b0}}, pixel});
    assign wt_s = {{(PROD_W-DATA_W){weight[DATA_W-1]}}, weight};
    assign prod = px_s * wt_s;

    always_comb begin
        term = '0;
        if (en && !zero) begin
            term = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
        sum = acc + term;
        rnd = (sum + RND_C) >>> FRAC;
        if (rnd[ACC_W-1]) begin
            res = '0;
        end else if (|rnd[ACC_W-2:DATA_W]) begin
            res = '1;
        end else begin
            res = rnd[DATA_W-1:0];
        end
    end

    // The result is taken from the combined sum, so clearing on the
    // last tap still reports that tap's contribution.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/conv_engine.sv
// 3x3 zero-padded convolution over a 64x64 image read from single-port SRAM.
// Ports: i_start/i_kernel/i_stride/i_dilation/i_weight job setup, SRAM read
// port (o_sram_*, i_sram_q), result stream (o_out_*), o_busy/o_err/o_done.
module conv_engine
    import conv_engine_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [7:0]                i_kernel,
    input  logic [7:0]                i_stride,
    input  logic [7:0]                i_dilation,
    input  logic [NTAPS*DATA_W-1:0]   i_weight,
    output logic [ADDR_W-1:0]         o_sram_addr,
    output logic                      o_sram_cen,
    output logic                      o_sram_wen,
    input  logic [DATA_W-1:0]         i_sram_q,
    output logic [DATA_W-1:0]         o_out_data,
    output logic [ADDR_W-1:0]         o_out_addr,
    output logic                      o_out_valid,
    output logic                      o_busy,
    output logic                      o_err,
    output logic                      o_done
);

    // Slot NTAPS of each pixel issues nothing; it drains the last tap.
    localparam logic [3:0] T_LAST = 4'(NTAPS);

    state_t state;
    state_t nxt;

    logic                        legal;
    logic                        accept;
    logic                        s2;
    logic                        d2;
    logic [NTAPS*DATA_W-1:0]     wts;
    logic [3:0]                  t;
    logic [1:0]                  ti;
    logic [1:0]                  tj;
    logic [CRD_W-1:0]            r;
    logic [CRD_W-1:0]            c;
    logic [CRD_W-1:0]            nmax;
    logic [CRD_W-1:0]            cr;
    logic [CRD_W-1:0]            cc;
    logic [ADDR_W-1:0]           idx;
    logic                        tail;
    logic signed [CRD_W+1:0]     dv;
    logic signed [CRD_W+1:0]     offr;
    logic signed [CRD_W+1:0]     offc;
    logic signed [CRD_W+1:0]     rr;
    logic signed [CRD_W+1:0]     cl;
    logic                        issue;
    logic                        oob;
    logic                        p_vld;
    logic                        p_zero;
    logic [3:0]                  p_tap;
    logic signed [DATA_W-1:0]    w_sel;
    logic                        mac_clr;
    logic [DATA_W-1:0]           mac_res;
    logic signed [ACC_W-1:0]     unused_acc;
    logic                        err;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic [ADDR_W-1:0]           out_addr;

    assign legal  = params_ok(i_kernel, i_stride, i_dilation);
    assign accept = (state == ST_IDLE) && i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: if (accept) nxt = legal ? ST_RUN : ST_DONE;
            ST_RUN:  if (tail) nxt = ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Tap coordinates relative to the output centre; out-of-image taps
    // show up as nonzero bits above the coordinate field.
    always_comb begin
        nmax = s2 ? CRD_W'(IMG_W/2 - 1) : CRD_W'(IMG_W - 1);
        cr   = s2 ? {r[CRD_W-2:0], 1'b0} : r;
        cc   = s2 ? {c[CRD_W-2:0], 1'b0} : c;
        dv   = d2 ? (CRD_W+2)'(2) : (CRD_W+2)'(1);
        offr = '0;
        offc = '0;
        if (ti == 2'd0) offr = -dv;
        else if (ti == 2'd2) offr = dv;
        if (tj == 2'd0) offc = -dv;
        else if (tj == 2'd2) offc = dv;
        rr    = $signed({2'b00, cr}) + offr;
        cl    = $signed({2'b00, cc}) + offc;
        oob   = (rr[CRD_W+1:CRD_W] != 2'b00) ||
                (cl[CRD_W+1:CRD_W] != 2'b00);
        issue = (state == ST_RUN) && !tail && (t < T_LAST);
    end

    always_comb begin
        o_busy      = (state != ST_IDLE);
        o_done      = (state == ST_DONE);
        o_sram_wen  = 1'b1;
        o_sram_cen  = 1'b1;
        o_sram_addr = '0;
        if (issue && !oob) begin
            o_sram_cen  = 1'b0;
            o_sram_addr = {rr[CRD_W-1:0], cl[CRD_W-1:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2  <= 1'b0;
            d2  <= 1'b0;
            wts <= '0;
            err <= 1'b0;
        end else if (accept) begin
            s2  <= (i_stride == S_MAX);
            d2  <= (i_dilation == D_MAX);
            wts <= i_weight;
            err <= !legal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            t    <= '0;
            ti   <= '0;
            tj   <= '0;
            r    <= '0;
            c    <= '0;
            idx  <= '0;
            tail <= 1'b0;
        end else if (accept) begin
            t    <= '0;
            ti   <= '0;
            tj   <= '0;
            r    <= '0;
            c    <= '0;
            idx  <= '0;
            tail <= 1'b0;
        end else if ((state == ST_RUN) && !tail) begin
            if (t == T_LAST) begin
                t   <= '0;
                ti  <= '0;
                tj  <= '0;
                idx <= idx + 1'b1;
                if ((r == nmax) && (c == nmax)) begin
                    tail <= 1'b1;
                end else if (c == nmax) begin
                    c <= '0;
                    r <= r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end else begin
                t <= t + 1'b1;
                if (tj == 2'd2) begin
                    tj <= '0;
                    ti <= ti + 1'b1;
                end else begin
                    tj <= tj + 1'b1;
                end
            end
        end
    end

    // Tap tag travels with the SRAM read so data and weight line up.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p_vld  <= 1'b0;
            p_zero <= 1'b0;
            p_tap  <= '0;
        end else begin
            p_vld  <= issue;
            p_zero <= oob;
            p_tap  <= t;
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (p_tap == 4'(k)) w_sel = wts[DATA_W*k +: DATA_W];
        end
    end

    assign mac_clr = (state != ST_RUN) || (t == T_LAST);

    conv_mac u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (p_vld),
        .zero    (p_zero),
        .clr     (mac_clr),
        .pixel   (i_sram_q),
        .weight  (w_sel),
        .acc     (unused_acc),
        .res     (mac_res)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if ((state == ST_RUN) && !tail && (t == T_LAST)) begin
            out_valid <= 1'b1;
            out_data  <= mac_res;
            out_addr  <= idx;
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign o_out_valid = out_valid;
    assign o_out_data  = out_data;
    assign o_out_addr  = out_addr;
    assign o_err       = err;

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: SRAM model, arithmetic reference of
// the convolution, directed frames plus randomized image/weight frames.
module tb_conv_engine;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_kernel;
    logic [7:0]  i_stride;
    logic [7:0]  i_dilation;
    logic [71:0] i_weight;
    logic [11:0] o_sram_addr;
    logic        o_sram_cen;
    logic        o_sram_wen;
    logic [7:0]  i_sram_q;
    logic [7:0]  o_out_data;
    logic [11:0] o_out_addr;
    logic        o_out_valid;
    logic        o_busy;
    logic        o_err;
    logic        o_done;

    conv_engine dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_kernel    (i_kernel),
        .i_stride    (i_stride),
        .i_dilation  (i_dilation),
        .i_weight    (i_weight),
        .o_sram_addr (o_sram_addr),
        .o_sram_cen  (o_sram_cen),
        .o_sram_wen  (o_sram_wen),
        .i_sram_q    (i_sram_q),
        .o_out_data  (o_out_data),
        .o_out_addr  (o_out_addr),
        .o_out_valid (o_out_valid),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [7:0] mem [4096];
    int wts [9];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    int oq_d[$];
    int oq_a[$];
    int rdq[$];
    int first_v = -1;
    int done_cyc = -1;
    int n_done = 0;
    int n_rd = 0;
    int p0 = -100;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Unread cycles return noise so padding taps must really be zeroed.
    always @(posedge i_clk) begin
        if (!o_sram_cen) i_sram_q <= mem[o_sram_addr];
        else i_sram_q <= 8'($urandom);
    end

    always @(negedge i_clk) begin
        if (o_out_valid) begin
            oq_d.push_back(int'(o_out_data));
            oq_a.push_back(int'(o_out_addr));
            if (first_v < 0) first_v = cyc;
        end
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (!o_sram_cen) begin
            n_rd++;
            if (cyc >= p0 && cyc <= p0 + 8) rdq.push_back(int'(o_sram_addr));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int od(input int i);
        return (i < oq_d.size()) ? oq_d[i] : -1;
    endfunction

    function automatic int oa(input int i);
        return (i < oq_a.size()) ? oq_a[i] : -1;
    endfunction

    // Sum of in-image pixel*weight around (r*s, c*s), rounded and clamped.
    function automatic int ref_px(input int r, input int c, input int s, input int d);
        int sum;
        int y;
        int x;
        int v;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                y = r * s + (i - 1) * d;
                x = c * s + (j - 1) * d;
                if (y >= 0 && y < 64 && x >= 0 && x < 64)
                    sum += int'(mem[y * 64 + x]) * wts[3 * i + j];
            end
        end
        v = (sum + 64) >>> 7;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic [71:0] pack_w();
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[8 * k +: 8] = 8'(wts[k]);
        return w;
    endfunction

    task automatic fill(input int pix, input int w);
        for (int a = 0; a < 4096; a++) mem[a] = 8'(pix);
        for (int k = 0; k < 9; k++) wts[k] = w;
    endtask

    task automatic clear_mon();
        oq_d.delete();
        oq_a.delete();
        rdq.delete();
        first_v = -1;
        done_cyc = -1;
        n_done = 0;
        n_rd = 0;
    endtask

    task automatic start_frame(input int k, input int s, input int d, output int x);
        @(negedge i_clk);
        clear_mon();
        i_kernel = 8'(k);
        i_stride = 8'(s);
        i_dilation = 8'(d);
        i_weight = pack_w();
        x = cyc;
        p0 = cyc + 1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_weight = {$urandom, $urandom, 8'($urandom)};
        i_stride = 8'($urandom);
        i_dilation = 8'($urandom);
        i_kernel = 8'($urandom);
    endtask

    task automatic wait_done(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (n_done > 0) break;
            @(negedge i_clk);
            #1;
        end
        chk({tag, ":done_seen"}, 32'(n_done > 0), 1);
    endtask

    task automatic check_frame(input string tag, input int s, input int d, input int x);
        int n;
        int m;
        int nerr;
        int first;
        n = 64 / s;
        m = n * n;
        nerr = 0;
        first = -1;
        chk({tag, ":count"}, oq_d.size(), m);
        chk({tag, ":first_valid_cyc"}, first_v, x + 11);
        chk({tag, ":done_cyc"}, done_cyc, x + 2 + 10 * m);
        chk({tag, ":n_done"}, n_done, 1);
        chk({tag, ":err"}, o_err, 0);
        for (int i = 0; i < m && i < oq_d.size(); i++) begin
            if (oq_a[i] != i || oq_d[i] != ref_px(i / n, i % n, s, d)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("%s: first wrong output index %0d data=%0d addr=%0d",
                     tag, first, oq_d[first], oq_a[first]);
        chk({tag, ":wrong_pixels"}, nerr, 0);
    endtask

    int x;
    int s_r;
    int d_r;
    int sz;

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_kernel = 8'd0;
        i_stride = 8'd0;
        i_dilation = 8'd0;
        i_weight = '0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst:cen", o_sram_cen, 1);
        chk("rst:wen", o_sram_wen, 1);
        chk("rst:valid", o_out_valid, 0);
        chk("rst:data", o_out_data, 0);
        chk("rst:oaddr", o_out_addr, 0);
        chk("rst:busy", o_busy, 0);
        chk("rst:done", o_done, 0);
        chk("rst:err", o_err, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        fill(100, 16);
        start_frame(3, 1, 1, x);
        chk("s1:busy", o_busy, 1);
        wait_done("s1", 41100);
        check_frame("s1", 1, 1, x);
        chk("s1:corner", od(0), 50);
        chk("s1:edge", od(5), 75);
        chk("s1:interior", od(65), 113);
        chk("s1:last_addr", oa(4095), 4095);

        start_frame(3, 2, 2, x);
        wait_done("s2d2", 10400);
        check_frame("s2d2", 2, 2, x);
        chk("s2d2:corner", od(0), 50);
        chk("s2d2:p11", od(33), 113);
        chk("s2d2:nreads0", rdq.size(), 4);
        chk("s2d2:rd0", rdq.size() > 0 ? rdq[0] : -1, 0);
        chk("s2d2:rd1", rdq.size() > 1 ? rdq[1] : -1, 2);
        chk("s2d2:rd2", rdq.size() > 2 ? rdq[2] : -1, 128);
        chk("s2d2:rd3", rdq.size() > 3 ? rdq[3] : -1, 130);

        start_frame(3, 3, 1, x);
        wait_done("ill_s3", 20);
        chk("ill_s3:done_cyc", done_cyc, x + 1);
        chk("ill_s3:err", o_err, 1);
        chk("ill_s3:outs", oq_d.size(), 0);
        chk("ill_s3:reads", n_rd, 0);
        @(negedge i_clk);
        #1;
        chk("ill_s3:busy", o_busy, 0);

        start_frame(5, 1, 1, x);
        wait_done("ill_k5", 20);
        chk("ill_k5:done_cyc", done_cyc, x + 1);
        chk("ill_k5:err", o_err, 1);
        chk("ill_k5:outs", oq_d.size(), 0);
        chk("ill_k5:reads", n_rd, 0);

        fill(255, -128);
        start_frame(3, 2, 1, x);
        wait_done("neg", 10400);
        check_frame("neg", 2, 1, x);
        chk("neg:corner", od(0), 0);
        chk("neg:p11", od(33), 0);

        fill(255, 127);
        start_frame(3, 2, 2, x);
        wait_done("pos", 10400);
        check_frame("pos", 2, 2, x);
        chk("pos:p11", od(33), 255);

        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        for (int k = 0; k < 9; k++) wts[k] = $urandom_range(255) - 128;
        start_frame(3, 1, 1, x);
        for (int i = 0; i < 6000; i++) begin
            if (oq_d.size() >= 500) break;
            @(negedge i_clk);
            #1;
        end
        chk("rst_mid:reached500", 32'(oq_d.size() >= 500), 1);
        i_rst_n = 1'b0;
        #1;
        sz = oq_d.size();
        chk("rst_mid:valid", o_out_valid, 0);
        chk("rst_mid:data", o_out_data, 0);
        chk("rst_mid:oaddr", o_out_addr, 0);
        chk("rst_mid:cen", o_sram_cen, 1);
        chk("rst_mid:busy", o_busy, 0);
        chk("rst_mid:done", o_done, 0);
        repeat (20) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        #1;
        chk("rst_mid:no_done", n_done, 0);
        chk("rst_mid:no_more_outs", oq_d.size(), sz);

        for (int k = 0; k < 9; k++) wts[k] = $urandom_range(255) - 128;
        s_r = 2;
        d_r = $urandom_range(2, 1);
        start_frame(3, s_r, d_r, x);
        wait_done("rand", 10400);
        check_frame("rand", s_r, d_r, x);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
